ttfs_event_scheduler: RTL and testbench

//  Sequences the TTFS charge datapath for one tick: pops input AER events from the spike-core FIFO and sweeps

---
 rtl/ttfs_event_scheduler_pkg.sv | 24 ++
 rtl/ttfs_event_scheduler_sweep.sv | 53 +++++
 rtl/ttfs_event_scheduler.sv | 145 ++++++++++++++
 tb/tb_ttfs_event_scheduler.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ttfs_event_scheduler_pkg.sv
// Shared types and defaults for the TTFS event scheduler.
//   sched_state_e : scheduler FSM states
//   sweep_phase_e : per-neuron sweep phase (read/integrate, then write-back)
package ttfs_event_scheduler_pkg;

  localparam int N_DEF = 256;
  localparam int M_DEF = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_POP,
    S_LATCH,
    S_SWEEP,
    S_TREF,
    S_DONE
  } sched_state_e;

  typedef enum logic {
    PH_READ,
    PH_WRITE
  } sweep_phase_e;

endpackage

// File: rtl/ttfs_event_scheduler_sweep.sv
// Neuron sweep counter: walks idx 0..limit, two phases per neuron.
//   CLK, RSTN : clock, async active-low reset
//   clear_i   : return to idx 0 / PH_READ (abort)
//   load_i    : start a new sweep, captures limit_i
//   step_i    : advance one phase
//   limit_i   : last index of the sweep (inclusive)
//   idx_o     : current neuron index
//   phase_o   : current phase
//   last_o    : write-back phase of the last neuron
module neuron_sweep_counter
  import ttfs_event_scheduler_pkg::*;
#(
  parameter int M = M_DEF
) (
  input  logic         CLK,
  input  logic         RSTN,
  input  logic         clear_i,
  input  logic         load_i,
  input  logic         step_i,
  input  logic [M-1:0] limit_i,
  output logic [M-1:0] idx_o,
  output sweep_phase_e phase_o,
  output logic         last_o
);

  logic [M-1:0] limit;

  assign last_o = (idx_o == limit) && (phase_o == PH_WRITE);

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      idx_o   <= '0;
      phase_o <= PH_READ;
      limit   <= '0;
    end else if (clear_i) begin
      idx_o   <= '0;
      phase_o <= PH_READ;
    end else if (load_i) begin
      idx_o   <= '0;
      phase_o <= PH_READ;
      limit   <= limit_i;
    end else if (step_i) begin
      if (phase_o == PH_READ) begin
        phase_o <= PH_WRITE;
      end else begin
        phase_o <= PH_READ;
        // Hold idx on the last neuron so a full-range sweep never wraps to 0.
        if (!last_o) idx_o <= idx_o + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ttfs_event_scheduler.sv
// TTFS event scheduler: pops AER events and sweeps all neurons per event
// (read then write-back phase), then runs one refractory sweep per tick.
//   CLK, RSTN         : clock, async active-low reset
//   start_i, abort_i  : begin inference / return to IDLE (abort wins)
//   max_neuron_i      : last neuron swept (inclusive), sampled at sweep start
//   fifo_*            : event FIFO pop interface (data valid cycle after pop)
//   spikecore_done_i  : spike core finished this tick
//   inference_done_i  : stop inference (checked only between sweeps)
//   count_o           : source event address of the current sweep
//   neuron_idx_o      : neuron being updated
//   neuron_event_o/neuron_write_o/neuron_tref_o/charge_enable_o : datapath strobes
//   tick_done_o, finished_o : one-cycle completion pulses
//   busy_o, evt_cnt_o : not idle / saturating events-this-tick count
module ttfs_event_scheduler
  import ttfs_event_scheduler_pkg::*;
#(
  parameter int N          = N_DEF,
  parameter int M          = M_DEF,
  parameter int INPUT_RESO = 8,
  parameter int EVT_CNT_W  = 16
) (
  input  logic                 CLK,
  input  logic                 RSTN,
  input  logic                 start_i,
  input  logic                 abort_i,
  input  logic [M-1:0]         max_neuron_i,
  output logic                 fifo_r_en_o,
  input  logic [M-1:0]         fifo_r_data_i,
  input  logic                 fifo_empty_i,
  input  logic                 spikecore_done_i,
  input  logic                 inference_done_i,
  output logic [M-1:0]         count_o,
  output logic [M-1:0]         neuron_idx_o,
  output logic                 neuron_event_o,
  output logic                 neuron_write_o,
  output logic                 neuron_tref_o,
  output logic                 charge_enable_o,
  output logic                 tick_done_o,
  output logic                 finished_o,
  output logic                 busy_o,
  output logic [EVT_CNT_W-1:0] evt_cnt_o
);

  localparam logic [M-1:0] LAST_IDX = M'(N - 1);

  sched_state_e state, state_n;
  sweep_phase_e cnt_phase;
  logic         cnt_load, cnt_step, cnt_last;
  logic         tick_n, fin_n;
  logic [M-1:0] sweep_limit;

  // Never sweep past the physical neuron array.
  assign sweep_limit = (max_neuron_i > LAST_IDX) ? LAST_IDX : max_neuron_i;

  neuron_sweep_counter #(.M(M)) u_sweep (
    .CLK     (CLK),
    .RSTN    (RSTN),
    .clear_i (abort_i),
    .load_i  (cnt_load),
    .step_i  (cnt_step),
    .limit_i (sweep_limit),
    .idx_o   (neuron_idx_o),
    .phase_o (cnt_phase),
    .last_o  (cnt_last)
  );

  always_comb begin
    state_n  = state;
    cnt_load = 1'b0;
    cnt_step = 1'b0;
    tick_n   = 1'b0;
    fin_n    = 1'b0;
    if (abort_i) begin
      state_n = S_IDLE;
    end else begin
      case (state)
        S_IDLE:  if (start_i) state_n = S_WAIT;
        S_WAIT: begin
          // Queued events are drained before the refractory sweep.
          if (inference_done_i) begin
            state_n = S_IDLE;
            fin_n   = 1'b1;
          end else if (!fifo_empty_i) begin
            state_n = S_POP;
          end else if (spikecore_done_i) begin
            state_n  = S_TREF;
            cnt_load = 1'b1;
          end
        end
        S_POP:   state_n = S_LATCH;
        S_LATCH: begin
          state_n  = S_SWEEP;
          cnt_load = 1'b1;
        end
        S_SWEEP: begin
          cnt_step = 1'b1;
          if (cnt_last) state_n = S_WAIT;
        end
        S_TREF: begin
          cnt_step = 1'b1;
          if (cnt_last) state_n = S_DONE;
        end
        S_DONE: begin
          // Stopping inference takes precedence over reporting the tick.
          if (inference_done_i) begin
            state_n = S_IDLE;
            fin_n   = 1'b1;
          end else begin
            state_n = S_WAIT;
            tick_n  = 1'b1;
          end
        end
        default: state_n = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state       <= S_IDLE;
      tick_done_o <= 1'b0;
      finished_o  <= 1'b0;
      count_o     <= '0;
      evt_cnt_o   <= '0;
    end else begin
      state       <= state_n;
      tick_done_o <= tick_n;
      finished_o  <= fin_n;
      if (state == S_LATCH && !abort_i) begin
        count_o <= fifo_r_data_i;
        if (evt_cnt_o != '1) evt_cnt_o <= evt_cnt_o + EVT_CNT_W'(1);
      end
      if (state == S_DONE) evt_cnt_o <= '0;
    end
  end

  // Strobes decode registered state only; no input reaches them combinationally.
  assign fifo_r_en_o     = (state == S_POP);
  assign neuron_event_o  = (state == S_SWEEP || state == S_TREF) && (cnt_phase == PH_READ);
  assign neuron_write_o  = (state == S_SWEEP || state == S_TREF) && (cnt_phase == PH_WRITE);
  assign neuron_tref_o   = (state == S_TREF);
  assign charge_enable_o = (state == S_SWEEP);
  assign busy_o          = (state != S_IDLE);

endmodule

// File: tb/tb_ttfs_event_scheduler.sv
module tb_ttfs_event_scheduler;
  localparam int M  = 8;
  localparam int EW = 2;

  logic          CLK = 1'b0, RSTN = 1'b0;
  logic          start_i, abort_i, fifo_empty_i, spikecore_done_i, inference_done_i;
  logic [M-1:0]  max_neuron_i, fifo_r_data_i;
  logic          fifo_r_en_o, neuron_event_o, neuron_write_o, neuron_tref_o;
  logic          charge_enable_o, tick_done_o, finished_o, busy_o;
  logic [M-1:0]  count_o, neuron_idx_o;
  logic [EW-1:0] evt_cnt_o;

  always #5 CLK = ~CLK;

  ttfs_event_scheduler #(.N(256), .M(M), .INPUT_RESO(8), .EVT_CNT_W(EW)) dut (
    .CLK(CLK), .RSTN(RSTN), .start_i(start_i), .abort_i(abort_i),
    .max_neuron_i(max_neuron_i), .fifo_r_en_o(fifo_r_en_o),
    .fifo_r_data_i(fifo_r_data_i), .fifo_empty_i(fifo_empty_i),
    .spikecore_done_i(spikecore_done_i), .inference_done_i(inference_done_i),
    .count_o(count_o), .neuron_idx_o(neuron_idx_o), .neuron_event_o(neuron_event_o),
    .neuron_write_o(neuron_write_o), .neuron_tref_o(neuron_tref_o),
    .charge_enable_o(charge_enable_o), .tick_done_o(tick_done_o),
    .finished_o(finished_o), .busy_o(busy_o), .evt_cnt_o(evt_cnt_o)
  );

  // Strobe vector: {pop, event, write, tref, charge, tick, finished}
  localparam logic [6:0] S_POP = 7'b1000000, S_RD  = 7'b0100100, S_WR   = 7'b0010100;
  localparam logic [6:0] S_TRD = 7'b0101000, S_TWR = 7'b0011000, S_TICK = 7'b0000010;
  localparam logic [6:0] S_FIN = 7'b0000001;

  typedef struct packed {
    logic [6:0]    sig;
    logic [M-1:0]  cnt;
    logic [M-1:0]  idx;
    logic [EW-1:0] evt;
    logic [2:0]    msk;   // compare {cnt, idx, evt}
  } rec_t;

  rec_t         exp_q[$];
  logic [M-1:0] fq[$];
  int           checks = 0, errors = 0;
  logic [EW-1:0] prev_evt = '0;

  function automatic logic [6:0] strobes();
    return {fifo_r_en_o, neuron_event_o, neuron_write_o, neuron_tref_o,
            charge_enable_o, tick_done_o, finished_o};
  endfunction

  // FIFO model: pop on the strobe, data presented before the LATCH edge.
  always @(negedge CLK) begin
    if (fifo_r_en_o && fq.size() != 0) begin
      fifo_r_data_i = fq.pop_front();
      fifo_empty_i  = (fq.size() == 0);
    end
  end

  // Monitor: every cycle with any strobe set must match the next expected record.
  always @(negedge CLK) begin
    logic [6:0] s;
    rec_t e;
    s = strobes();
    if (s != 7'd0) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output: strobes=%b idx=%0d count=%0d, expected no output", s, neuron_idx_o, count_o);
      end else begin
        e = exp_q.pop_front();
        if (s != e.sig || (e.msk[2] && count_o != e.cnt) || (e.msk[1] && neuron_idx_o != e.idx) ||
            (e.msk[0] && prev_evt != e.evt)) begin
          errors++;
          $display("FAIL scoreboard: got strobes=%b count=%0d idx=%0d evt=%0d, expected strobes=%b count=%0d idx=%0d evt=%0d",
                   s, count_o, neuron_idx_o, prev_evt, e.sig, e.cnt, e.idx, e.evt);
        end
      end
    end
    prev_evt = evt_cnt_o;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic expect_rec(input logic [6:0] s, input logic [M-1:0] c, input logic [M-1:0] i,
                            input logic [EW-1:0] e, input logic [2:0] m);
    rec_t r;
    r.sig = s; r.cnt = c; r.idx = i; r.evt = e; r.msk = m;
    exp_q.push_back(r);
  endtask

  task automatic exp_event(input logic [M-1:0] a, input int max);
    expect_rec(S_POP, '0, '0, '0, 3'b000);
    for (int i = 0; i <= max; i++) begin
      expect_rec(S_RD, a, i[M-1:0], '0, 3'b110);
      expect_rec(S_WR, a, i[M-1:0], '0, 3'b110);
    end
  endtask

  task automatic exp_tref(input int max);
    for (int i = 0; i <= max; i++) begin
      expect_rec(S_TRD, '0, i[M-1:0], '0, 3'b010);
      expect_rec(S_TWR, '0, i[M-1:0], '0, 3'b010);
    end
  endtask

  task automatic push_evt(input logic [M-1:0] a);
    fq.push_back(a);
    fifo_empty_i = 1'b0;
  endtask

  task automatic start_pulse();
    @(negedge CLK); start_i = 1'b1;
    @(negedge CLK); start_i = 1'b0;
  endtask

  task automatic drain(input int budget, input string nm);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge CLK); n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: %0d records outstanding, expected 0", nm, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic wait_tick(input int budget, input string nm, output int n);
    bit seen = 0;
    n = 0;
    while (!seen && n < budget) begin
      @(negedge CLK); n++;
      if (tick_done_o) seen = 1;
    end
    chk({nm, "_tick_seen"}, 32'(seen), 32'd1);
  endtask

  task automatic wait_read(input logic tref, input logic [M-1:0] k, input int budget, input string nm);
    bit seen = 0;
    int n = 0;
    while (!seen && n < budget) begin
      @(negedge CLK); n++;
      if (neuron_event_o && neuron_tref_o == tref && neuron_idx_o == k) seen = 1;
    end
    chk({nm, "_reached"}, 32'(seen), 32'd1);
  endtask

  task automatic do_abort(input string nm);
    @(negedge CLK); abort_i = 1'b1;
    @(negedge CLK); abort_i = 1'b0;
    chk(nm, {busy_o, strobes()}, 32'd0);
  endtask

  initial begin
    #500000;
    errors++;
    $display("FAIL watchdog: simulation did not complete");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1);
  end

  initial begin
    int n;
    start_i = 0; abort_i = 0; max_neuron_i = '0; fifo_r_data_i = '0; fifo_empty_i = 1'b1;
    spikecore_done_i = 0; inference_done_i = 0;
    repeat (3) @(negedge CLK);
    chk("reset_outputs", {busy_o, strobes(), neuron_idx_o, count_o, evt_cnt_o}, 32'd0);
    RSTN = 1'b1;
    repeat (3) @(negedge CLK);
    chk("idle_without_start", {busy_o, strobes()}, 32'd0);

    // 1: two events, max=3, spike core already done -> drain then tref
    max_neuron_i = 8'd3;
    push_evt(8'd5); push_evt(8'd9);
    exp_event(8'd5, 3); exp_event(8'd9, 3); exp_tref(3);
    expect_rec(S_TICK, '0, '0, 2'd2, 3'b001);
    spikecore_done_i = 1'b1;
    start_pulse();
    wait_tick(200, "t1", n);
    spikecore_done_i = 1'b0;
    drain(10, "t1");
    repeat (4) @(negedge CLK);
    do_abort("t1_abort_idle");

    // 2: empty FIFO, max=0, spike core done later -> tick 4 cycles after it is seen
    max_neuron_i = 8'd0;
    start_pulse();
    repeat (8) @(negedge CLK);
    chk("t2_waiting", {busy_o, strobes()}, 32'h80);
    exp_tref(0);
    expect_rec(S_TICK, '0, '0, 2'd0, 3'b001);
    spikecore_done_i = 1'b1;
    wait_tick(20, "t2", n);
    spikecore_done_i = 1'b0;
    chk("t2_tick_latency", 32'(n), 32'd4);
    drain(5, "t2");
    do_abort("t2_abort_idle");

    // 3: inference_done mid-sweep; max change mid-sweep ignored
    max_neuron_i = 8'd7;
    push_evt(8'd3);
    exp_event(8'd3, 7);
    expect_rec(S_FIN, '0, '0, '0, 3'b000);
    start_pulse();
    wait_read(1'b0, 8'd2, 30, "t3");
    inference_done_i = 1'b1;
    max_neuron_i = 8'd1;
    drain(40, "t3");
    @(negedge CLK);
    chk("t3_idle_after_finish", 32'(busy_o), 32'd0);
    inference_done_i = 1'b0;

    // 4: abort at SWEEP idx=2 phase0, then restart
    max_neuron_i = 8'd3;
    push_evt(8'd6);
    expect_rec(S_POP, '0, '0, '0, 3'b000);
    for (int i = 0; i < 2; i++) begin
      expect_rec(S_RD, 8'd6, i[M-1:0], '0, 3'b110);
      expect_rec(S_WR, 8'd6, i[M-1:0], '0, 3'b110);
    end
    expect_rec(S_RD, 8'd6, 8'd2, '0, 3'b110);
    start_pulse();
    wait_read(1'b0, 8'd2, 30, "t4");
    abort_i = 1'b1;
    @(negedge CLK); abort_i = 1'b0;
    chk("t4_abort_quiet", {busy_o, strobes()}, 32'd0);
    drain(2, "t4_abort");
    max_neuron_i = 8'd0;
    push_evt(8'd7);
    exp_event(8'd7, 0);
    start_pulse();
    drain(20, "t4_restart");
    do_abort("t4_abort_idle");

    // 5: five events saturate a 2-bit counter; full 256-neuron sweep
    max_neuron_i = 8'd0;
    for (int k = 1; k <= 5; k++) begin
      push_evt(k[M-1:0]);
      exp_event(k[M-1:0], 0);
    end
    start_pulse();
    drain(60, "t5_events");
    chk("t5_evt_saturated", 32'(evt_cnt_o), 32'd3);
    exp_tref(0);
    expect_rec(S_TICK, '0, '0, 2'd3, 3'b001);
    spikecore_done_i = 1'b1;
    wait_tick(20, "t5a", n);
    spikecore_done_i = 1'b0;
    drain(5, "t5_tick");
    max_neuron_i = 8'd255;
    push_evt(8'hAA);
    exp_event(8'hAA, 255);
    drain(700, "t5_full_sweep");
    repeat (4) @(negedge CLK);
    exp_tref(255);
    expect_rec(S_TICK, '0, '0, 2'd1, 3'b001);
    spikecore_done_i = 1'b1;
    wait_tick(700, "t5b", n);
    spikecore_done_i = 1'b0;
    drain(5, "t5_tref");
    do_abort("t5_abort_idle");

    // 6: async reset mid-TREF
    max_neuron_i = 8'd3;
    spikecore_done_i = 1'b1;
    expect_rec(S_TRD, '0, 8'd0, '0, 3'b010);
    expect_rec(S_TWR, '0, 8'd0, '0, 3'b010);
    expect_rec(S_TRD, '0, 8'd1, '0, 3'b010);
    start_pulse();
    wait_read(1'b1, 8'd1, 20, "t6");
    #1 RSTN = 1'b0;
    #1 chk("t6_async_reset", {busy_o, strobes(), neuron_idx_o, count_o, evt_cnt_o}, 32'd0);
    spikecore_done_i = 1'b0;
    repeat (3) @(negedge CLK);
    RSTN = 1'b1;
    repeat (5) @(negedge CLK);
    chk("t6_stays_idle", {busy_o, strobes()}, 32'd0);
    drain(1, "t6_reset");
    max_neuron_i = 8'd0;
    push_evt(8'd4);
    exp_event(8'd4, 0);
    start_pulse();
    drain(20, "t6_restart");
    do_abort("t6_abort_idle");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
